pe_feeder: RTL
==============

# pe_feeder

Upstream operand feeder for the systolic `pe` stage. It buffers 16-bit A and B operand words written by the host side (UART command decoder) in two FIFOs. On command it issues a start pulse and the element count (`max_cntr`) to the PE, streams exactly N A-words and N B-words into it while honouring the PE full flags, and reports completion when the PE raises `fout`.

## Interface
Parameters:
- `DEPTH`, 16: entries per operand FIFO (power of two, 4..256)

Ports:
- `clk` in 1: single clock; all logic rising-edge
- `rst` in 1: synchronous, active-high reset
- `wr_en` in 1: host write strobe
- `wr_sel` in 1: 0 = A FIFO, 1 = B FIFO
- `wr_data` in 16: operand word
- `wr_ovf` out 1: sticky; write attempted to full FIFO
- `cmd_start` in 1: one-cycle command pulse
- `cmd_len` in 8: element count N
- `cmd_err` out 1: one-cycle pulse; command rejected
- `busy` out 1: FSM not IDLE
- `done` out 1: one-cycle pulse at completion
- `a_in` out 16, `awe` out 1: A word and its write enable to PE
- `b_in` out 16, `bwe` out 1: B word and its write enable to PE
- `start` out 1, `max_cntr` out 8: PE start pulse and count
- `aff`, `bff` in 1: PE A/B input full
- `fout` in 1: PE result-complete pulse

## Operation
- FSM states: IDLE, START, STREAM, WAIT, FIN.
- IDLE → START on `cmd_start` with N≠0. N is latched into `max_cntr` and into counters `a_left`/`b_left`.
- `cmd_start` with N=0, or while `busy`: ignored, `cmd_err` pulses next cycle.
- START: `start`=1 for exactly this one cycle; → STREAM.
- STREAM: A and B lanes are independent.
  - A lane pops when `a_left`≠0, A FIFO non-empty and `aff`=0. The popped word is registered onto `a_in` with `awe`=1 the following cycle, and `a_left` decrements. B lane is identical with `bff`.
  - → WAIT when both counters are 0 and the last write has issued.
- WAIT: → FIN on `fout`=1. A `fout` seen in STREAM is latched and honoured on entering WAIT.
- FIN: `done`=1 one cycle; → IDLE.
- FIFO write and pop in the same cycle are both allowed, count unchanged. A write to a full FIFO is dropped and sets `wr_ovf` until reset.
- `max_cntr` holds its value until the next accepted command.
- `a_in`/`b_in` hold the last word when the matching enable is low.
- Reset in any state: FSM to IDLE, both FIFOs emptied, all outputs 0 next edge.

## Timing
- Reset values: `wr_ovf`, `cmd_err`, `busy`, `done`, `a_in`, `awe`, `b_in`, `bwe`, `start`, `max_cntr` all 0.
- `cmd_start` at cycle t → `start`=1 and `busy`=1 at t+1; earliest `awe`/`bwe` at t+3.
- A FIFO word written at t is poppable at t+1.
- `aff` sampled at cycle c gates the pop at c; the resulting `awe` appears at c+1. The PE must assert full one entry early.
- Full throughput: one A and one B word per cycle with no stall.
- `fout` at cycle w in WAIT → `done` at w+1, `busy`=0 at w+2.

## Configuration
- `PE_FEEDER_ZERO_PAD_EN` defined:
  - In STREAM, an empty FIFO with `*_left`≠0 and full flag low issues word 0x0000 with its enable high and decrements the counter.
  - Sticky output `underrun` (1 bit, reset 0) is added.
- Undefined: the lane stalls on an empty FIFO until data arrives; no `underrun` port.

## Structure
- Shared package `pe_feeder_pkg`:
  - FSM state enum (IDLE=0, START=1, STREAM=2, WAIT=3, FIN=4, 3-bit)
  - `OPW`=16 operand width, `CNTW`=8 count width
- Sub-module `feeder_fifo`: synchronous FIFO, width `OPW`, depth `DEPTH`; flags `empty`/`full`; registered count. Instantiated twice (A, B).

## Test plan
- Write A=1,2,3 and B=4,5,6; `cmd_len`=3; `aff`=`bff`=0 → `start` one cycle, `max_cntr`=3, `a_in` 1,2,3 and `b_in` 4,5,6 on consecutive cycles; `fout` → `done` next cycle.
- Hold `aff`=1 for 4 cycles mid-stream, N=4 → no `awe` during the stall; B lane finishes independently; exactly 4 `awe` pulses total.
- Fill A FIFO to `DEPTH`=16, write one more → `wr_ovf`=1 and stays; count stays 16.
- `cmd_len`=0, and separately `cmd_start` while busy → `cmd_err` pulse, state unchanged.
- N=2, A FIFO holds 1 word: with macro → `a_in` 1 then 0x0000 and `underrun`=1; without → stall until second word is written.
- Assert `rst` during STREAM → all outputs 0 next cycle; a new 1-element command completes normally.

Source files
------------

// File: rtl/pe_feeder_pkg.sv
// Shared types and widths for the pe_feeder operand feeder.
package pe_feeder_pkg;

    localparam int OPW  = 16;
    localparam int CNTW = 8;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        STREAM = 3'd2,
        WAIT   = 3'd3,
        FIN    = 3'd4
    } state_e;

endpackage

// File: rtl/pe_feeder_if.sv
// Feeder-to-PE bus: operand lanes, start/count, and the PE's back-pressure/complete flags.
interface pe_feeder_if;
    import pe_feeder_pkg::*;

    logic [OPW-1:0]  a_in;
    logic            awe;
    logic [OPW-1:0]  b_in;
    logic            bwe;
    logic            start;
    logic [CNTW-1:0] max_cntr;
    logic            aff;
    logic            bff;
    logic            fout;

    modport master (output a_in, awe, b_in, bwe, start, max_cntr, input aff, bff, fout);
    modport slave  (input a_in, awe, b_in, bwe, start, max_cntr, output aff, bff, fout);

endinterface

// File: rtl/pe_feeder_fifo.sv
// Synchronous operand FIFO with show-ahead read data; full writes are dropped, empty reads ignored.
module feeder_fifo
    import pe_feeder_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic           clk,
    input  logic           rst,
    input  logic           wr_en_i,
    input  logic [OPW-1:0] wr_data_i,
    input  logic           rd_en_i,
    output logic [OPW-1:0] rd_data_o,
    output logic           empty_o,
    output logic           full_o
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [OPW-1:0] mem_q [DEPTH];
    logic [AW-1:0]  wptr_q, rptr_q;
    logic [CW-1:0]  count_q;
    logic           do_wr, do_rd;

    assign empty_o   = (count_q == '0);
    assign full_o    = (count_q == CW'(DEPTH));
    assign do_wr     = wr_en_i && !full_o;
    assign do_rd     = rd_en_i && !empty_o;
    assign rd_data_o = mem_q[rptr_q];

    always_ff @(posedge clk) begin
        if (do_wr) mem_q[wptr_q] <= wr_data_i;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (do_wr) wptr_q <= wptr_q + 1'b1;
            if (do_rd) rptr_q <= rptr_q + 1'b1;
            case ({do_wr, do_rd})
                2'b10:   count_q <= count_q + 1'b1;
                2'b01:   count_q <= count_q - 1'b1;
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/pe_feeder.sv
// Operand feeder for the systolic PE: two operand FIFOs, per-lane streaming, command FSM.
// Optional PE_FEEDER_ZERO_PAD_EN: empty lanes issue 0x0000 and set sticky underrun.
module pe_feeder
    import pe_feeder_pkg::*;
#(
    parameter int DEPTH = 16
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            wr_en,
    input  logic            wr_sel,
    input  logic [OPW-1:0]  wr_data,
    output logic            wr_ovf,
    input  logic            cmd_start,
    input  logic [CNTW-1:0] cmd_len,
    output logic            cmd_err,
    output logic            busy,
    output logic            done,
`ifdef PE_FEEDER_ZERO_PAD_EN
    output logic            underrun,
`endif
    pe_feeder_if.master     pe
);
    state_e                     state_q;
    logic                       busy_q, done_q, start_q, cmd_err_q, wr_ovf_q, fout_seen_q;
    logic [CNTW-1:0]            max_cntr_q;
    logic                       accept;

    logic [1:0]                 fifo_wr, fifo_empty, fifo_full, pe_full;
    logic [1:0]                 issue, pop, we_q;
    logic [1:0][OPW-1:0]        fifo_rdata, op_q;
    logic [1:0][CNTW-1:0]       left_q;

    assign pe_full = {pe.bff, pe.aff};
    assign accept  = cmd_start && (state_q == IDLE) && (cmd_len != '0);

    for (genvar l = 0; l < 2; l++) begin : g_lane
        assign fifo_wr[l] = wr_en && (wr_sel == 1'(l));

        feeder_fifo #(.DEPTH(DEPTH)) u_fifo (
            .clk       (clk),
            .rst       (rst),
            .wr_en_i   (fifo_wr[l]),
            .wr_data_i (wr_data),
            .rd_en_i   (pop[l]),
            .rd_data_o (fifo_rdata[l]),
            .empty_o   (fifo_empty[l]),
            .full_o    (fifo_full[l])
        );
    end

    // A lane issues a word when it owes one and the PE has room; pad mode issues even when empty.
    always_comb begin
        issue = '0;
        pop   = '0;
        for (int l = 0; l < 2; l++) begin
`ifdef PE_FEEDER_ZERO_PAD_EN
            issue[l] = (state_q == STREAM) && (left_q[l] != '0) && !pe_full[l];
`else
            issue[l] = (state_q == STREAM) && (left_q[l] != '0) && !pe_full[l] && !fifo_empty[l];
`endif
            pop[l] = issue[l] && !fifo_empty[l];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            op_q   <= '0;
            we_q   <= '0;
            left_q <= '0;
        end else begin
            we_q <= issue;
            for (int l = 0; l < 2; l++) begin
                if (accept) begin
                    left_q[l] <= cmd_len;
                end else if (issue[l]) begin
                    left_q[l] <= left_q[l] - 1'b1;
                    op_q[l]   <= fifo_empty[l] ? '0 : fifo_rdata[l];
                end
            end
        end
    end

`ifdef PE_FEEDER_ZERO_PAD_EN
    logic underrun_q;
    always_ff @(posedge clk) begin
        if (rst)                                  underrun_q <= 1'b0;
        else if (|(issue & fifo_empty))           underrun_q <= 1'b1;
    end
    assign underrun = underrun_q;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            start_q     <= 1'b0;
            cmd_err_q   <= 1'b0;
            wr_ovf_q    <= 1'b0;
            fout_seen_q <= 1'b0;
            max_cntr_q  <= '0;
        end else begin
            start_q   <= 1'b0;
            done_q    <= 1'b0;
            cmd_err_q <= cmd_start && ((state_q != IDLE) || (cmd_len == '0));
            if (wr_en && fifo_full[wr_sel]) wr_ovf_q <= 1'b1;
            case (state_q)
                IDLE: if (accept) begin
                    state_q     <= START;
                    start_q     <= 1'b1;
                    busy_q      <= 1'b1;
                    max_cntr_q  <= cmd_len;
                    fout_seen_q <= 1'b0;
                end
                START: state_q <= STREAM;
                STREAM: begin
                    // An early completion pulse is remembered until the stream drains.
                    if (pe.fout) fout_seen_q <= 1'b1;
                    if (left_q == '0) state_q <= WAIT;
                end
                WAIT: if (pe.fout || fout_seen_q) begin
                    state_q <= FIN;
                    done_q  <= 1'b1;
                end
                FIN: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
                default: begin
                    state_q <= IDLE;
                    busy_q  <= 1'b0;
                end
            endcase
        end
    end

    assign wr_ovf      = wr_ovf_q;
    assign cmd_err     = cmd_err_q;
    assign busy        = busy_q;
    assign done        = done_q;
    assign pe.a_in     = op_q[0];
    assign pe.awe      = we_q[0];
    assign pe.b_in     = op_q[1];
    assign pe.bwe      = we_q[1];
    assign pe.start    = start_q;
    assign pe.max_cntr = max_cntr_q;

endmodule
